// File: rtl/mult_div_unit_if.sv
// EX-stage <-> multiply/divide unit bundle: forwarded operands, op strobe,
// and the architectural HI/LO plus busy seen by MFHI/MFLO and the hazard unit.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;

    modport master (
        output A, B, start, mdu_op,
        input  HI, LO, busy
    );

    modport slave (
        input  A, B, start, mdu_op,
        output HI, LO, busy
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO. The result is computed at accept time
// into a shadow pair and committed to HI/LO when the busy countdown expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    logic [CW-1:0] counter, counter_nxt;
    logic          busy_q;
    logic [31:0]   hi_q, hi_nxt, lo_q, lo_nxt;
    logic [31:0]   sh_hi, sh_hi_nxt, sh_lo, sh_lo_nxt;
    logic          sh_wr, sh_wr_nxt;

    // ---------------- arithmetic datapath ----------------
    logic          is_signed_mul;
    logic [63:0]   mul_a, mul_b, product;
    logic          a_neg, b_neg;
    logic [31:0]   div_n, div_d, uq, ur, quot, rem;
    logic          div_by_zero;

    // Operands are extended to 64 bits so the low 64 bits of one multiplier
    // serve both the signed and the unsigned product.
    assign is_signed_mul = (bus.mdu_op == OP_MULT);
    assign mul_a   = {{32{is_signed_mul & bus.A[31]}}, bus.A};
    assign mul_b   = {{32{is_signed_mul & bus.B[31]}}, bus.B};
    assign product = mul_a * mul_b;

    // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign a_neg       = (bus.mdu_op == OP_DIV) & bus.A[31];
    assign b_neg       = (bus.mdu_op == OP_DIV) & bus.B[31];
    assign div_n       = a_neg ? -bus.A : bus.A;
    assign div_d       = b_neg ? -bus.B : bus.B;
    assign div_by_zero = (bus.B == 32'd0);
    assign uq          = div_by_zero ? 32'd0 : div_n / div_d;
    assign ur          = div_by_zero ? 32'd0 : div_n % div_d;
    assign quot        = (a_neg ^ b_neg) ? -uq : uq;
    assign rem         = a_neg ? -ur : ur;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi   <= '0;
            sh_lo   <= '0;
            sh_wr   <= 1'b0;
        end else begin
            counter <= counter_nxt;
            busy_q  <= (counter_nxt != '0);
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            sh_hi   <= sh_hi_nxt;
            sh_lo   <= sh_lo_nxt;
            sh_wr   <= sh_wr_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        counter_nxt = counter;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        sh_hi_nxt   = sh_hi;
        sh_lo_nxt   = sh_lo;
        sh_wr_nxt   = sh_wr;
        if (counter == '0) begin
            if (bus.start) begin
                case (bus.mdu_op)
                    OP_MULT, OP_MULTU: begin
                        counter_nxt = CW'(MULT_CYCLES);
                        sh_hi_nxt   = product[63:32];
                        sh_lo_nxt   = product[31:0];
                        sh_wr_nxt   = 1'b1;
                    end
                    OP_DIV, OP_DIVU: begin
                        counter_nxt = CW'(DIV_CYCLES);
                        sh_hi_nxt   = rem;
                        sh_lo_nxt   = quot;
                        sh_wr_nxt   = !div_by_zero;
                    end
                    OP_MTHI: hi_nxt = bus.A;
                    OP_MTLO: lo_nxt = bus.A;
                    default: ;
                endcase
            end
        end else begin
            // A start seen here is deliberately dropped: the hazard unit owns ordering.
            counter_nxt = counter - 1'b1;
            if (counter == CW'(1) && sh_wr) begin
                hi_nxt = sh_hi;
                lo_nxt = sh_lo;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.HI   = hi_q;
        bus.LO   = lo_q;
        bus.busy = busy_q;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Takes the same forwarded operands A and B as the ALU.
- Owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes busy so the hazard unit can stall any following MDU instruction until the result is committed.

Parameters:
MULT_CYCLES, 5, busy duration for MULT/MULTU (must be >=1)
DIV_CYCLES, 10, busy duration for DIV/DIVU (must be >=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
B  input  32  operand rt (divisor / multiplier)
start  input  1  one-cycle strobe from EX, valid MDU instruction present
mdu_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
HI  output  32  architectural HI register
LO  output  32  architectural LO register
busy  output  1  operation in flight, HI/LO not yet updated

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset (any cycle, including mid-operation):
  - HI=0, LO=0, busy=0, counter=0, shadow result cleared.
  - An in-flight operation is discarded; HI/LO stay 0.
- States:
  - IDLE (counter==0, busy=0).
  - RUN (counter>0, busy=1).
  - busy is a direct decode of counter!=0, registered; it has no combinational path from start.
- IDLE with start=1 and mdu_op 0-3:
  - The result is computed from A/B at that edge into shadow regs {sh_hi, sh_lo}.
  - counter loads MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
  - busy goes high next cycle.
- RUN: counter decrements each edge. On the 1->0 transition, HI<=sh_hi and LO<=sh_lo at the same edge.
  - busy is high for exactly N cycles.
  - New HI/LO are visible in the first cycle busy=0.
- MTHI/MTLO (ops 4,5) in IDLE with start=1:
  - HI<=A (op 4) or LO<=A (op 5) at that edge.
  - No busy cycle; the other register is unchanged.
- Reserved ops 6-7: no effect.
- start while busy=1: ignored entirely (no restart, no MTHI/MTLO write, shadow unchanged). The hazard unit guarantees this does not occur architecturally; the bench checks it is harmless.
- Arithmetic:
  - MULT: signed 32x32 -> 64-bit product; {HI,LO} = product.
  - MULTU: unsigned 32x32 -> 64-bit product; {HI,LO} = product.
  - DIV: signed, quotient truncated toward zero; LO = quotient, HI = remainder, remainder sign = dividend sign.
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
  - DIV/DIVU with B==0: operation runs the full DIV_CYCLES with busy, but HI/LO are left unchanged at commit.
- HI/LO are read combinationally by MFHI/MFLO in EX. Reading while busy=1 returns the old value; stalling is the controller's job.
- Back-to-back operations: start may be accepted in the same cycle busy first reads 0. That start computes from the already-committed HI/LO state and does not disturb it until its own commit.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV signed sign rules:
  - DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero:
  - MTHI A=0x11111111, then MTLO A=0x22222222 -> each written the next cycle with busy=0.
  - Then DIVU A=5, B=0 -> busy 10 cycles, HI=0x11111111 and LO=0x22222222 unchanged.
- DIVU A=100, B=7:
  - Assert start with MTLO A=0xDEAD in busy cycle 3 -> ignored.
  - After commit LO=14, HI=2.
  - reset mid-run on a second DIVU -> next cycle busy=0, HI=LO=0, and no commit occurs later.
- Back-to-back: MULT 6x7, then start DIVU 42/5 in the first busy=0 cycle -> LO=42, HI=0 visible that cycle; 10 cycles later LO=8, HI=2.
